// File: rtl/rca_share_sequencer.sv
// Shares one external SLICE-bit ripple adder between two round-robin requesters, LSB slice first.
// Result appears NSLICE+1 cycles after acceptance; no request is accepted while a result waits for rsp_ready.
module rca_share_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic [SLICE-1:0] add_a,
  output logic [SLICE-1:0] add_b,
  output logic             add_cin,
  input  logic [SLICE-1:0] add_s,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_id
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             id;
  logic             last_grant;
  logic             gnt0;
  logic             gnt1;
  logic             sel_sub;
  logic             last_slice;
  logic             run;

  // On contention the requester that did not win last time gets the slot.
  assign gnt0 = req0_valid && (!req1_valid || last_grant);
  assign gnt1 = req1_valid && !gnt0;
  assign req0_ready = (state == IDLE) && gnt0;
  assign req1_ready = (state == IDLE) && gnt1;
  assign sel_sub    = gnt1 ? req1_sub : req0_sub;

  assign run        = (state == RUN);
  assign last_slice = (idx == IW'(NSLICE - 1));
  assign a_sh       = opa >> (int'(idx) * SLICE);
  assign b_sh       = opb >> (int'(idx) * SLICE);
  assign add_a      = run ? a_sh[SLICE-1:0] : '0;
  assign add_b      = run ? b_sh[SLICE-1:0] : '0;
  assign add_cin    = run ? carry : 1'b0;
  assign rsp_valid  = (state == DONE);

  always_comb begin
    acc_nxt = acc;
    acc_nxt[int'(idx)*SLICE +: SLICE] = add_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      opa        <= '0;
      opb        <= '0;
      acc        <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      id         <= 1'b0;
      last_grant <= 1'b1;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            opa        <= gnt1 ? req1_a : req0_a;
            opb        <= (gnt1 ? req1_b : req0_b) ^ {WIDTH{sel_sub}};
            carry      <= sel_sub;
            idx        <= '0;
            id         <= gnt1;
            last_grant <= gnt1;
            state      <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= add_cout;
          idx   <= idx + 1'b1;
          if (last_slice) begin
            // Result registers change only here, so they stay put through DONE and after.
            rsp_sum  <= acc_nxt;
            rsp_cout <= add_cout;
            rsp_ovf  <= (add_a[SLICE-1] == add_b[SLICE-1]) && (add_s[SLICE-1] != add_a[SLICE-1]);
            rsp_id   <= id;
            idx      <= '0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_share_sequencer.sv
// Directed bench for rca_share_sequencer (32/8) with a behavioural 8-bit ripple adder slice.
module tb_rca_share_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic [7:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_ovf, rsp_id;
  logic [31:0] rsp_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  rca_share_sequencer #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_ovf(rsp_ovf), .rsp_id(rsp_id)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  // Requests are set up by the caller; this walks one op from grant through the response handshake.
  task automatic do_op(input bit gid, input logic [31:0] esum, input bit ecout, input bit eovf,
                       input bit cchk, input logic [3:0] cseq, input bit bchk, input logic [7:0] b0,
                       input int hold, input bit nvalid, input logic [31:0] na, input logic [31:0] nb);
    rsp_ready = (hold == 0);
    @(negedge clk);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("grant_ready", gid ? req1_ready : req0_ready, 1);
    chk("loser_ready", gid ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    if (gid) begin req1_valid = nvalid; req1_a = na; req1_b = nb; end
    else     begin req0_valid = nvalid; req0_a = na; req0_b = nb; end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("run_rsp_valid", rsp_valid, 0);
      chk("run_ready", {30'b0, req0_ready, req1_ready}, 0);
      if (cchk) chk("add_cin_seq", add_cin, cseq[c]);
      if (bchk && c == 0) chk("first_add_b", add_b, b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("done_valid", rsp_valid, 1);
    chk("done_sum", rsp_sum, esum);
    chk("done_cout", rsp_cout, ecout);
    chk("done_ovf", rsp_ovf, eovf);
    chk("done_id", rsp_id, gid);
    chk("done_add_a", add_a, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_sum", rsp_sum, esum);
      chk("hold_ready", {30'b0, req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_flags", {29'b0, rsp_cout, rsp_ovf, rsp_id}, 0);
    chk("rst_add", {15'b0, add_a, add_b, add_cin}, 0);
    chk("rst_ready", {30'b0, req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: wrap-around add, carry ripples through every slice
    req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_0001; req0_sub = 0;
    do_op(0, 32'h0000_0000, 1, 0, 1, 4'b1110, 1, 8'h01, 0, 0, 0, 0);

    // 2: positive overflow from requester 1
    req1_valid = 1; req1_a = 32'h7FFF_FFFF; req1_b = 32'h0000_0001; req1_sub = 0;
    do_op(1, 32'h8000_0000, 0, 1, 1, 4'b1110, 0, 8'h00, 0, 0, 0, 0);

    // 3: subtract with borrow
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd7; req0_sub = 1;
    do_op(0, 32'hFFFF_FFFE, 0, 0, 1, 4'b0001, 1, 8'hF8, 0, 0, 0, 0);
    req0_sub = 0;

    // 4: contested round robin after a fresh reset
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    req0_valid = 1; req0_a = 32'h1111_1111; req0_b = 32'h2222_2222;
    req1_valid = 1; req1_a = 32'h0100_0000; req1_b = 32'h0200_0000;
    do_op(0, 32'h3333_3333, 0, 0, 0, 4'b0, 0, 8'h00, 0, 1, 32'h10, 32'h20);
    do_op(1, 32'h0300_0000, 0, 0, 0, 4'b0, 0, 8'h00, 0, 1, 32'hFFFF_FFFF, 32'h2);
    do_op(0, 32'h0000_0030, 0, 0, 0, 4'b0, 0, 8'h00, 0, 0, 0, 0);
    do_op(1, 32'h0000_0001, 1, 0, 0, 4'b0, 0, 8'h00, 0, 0, 0, 0);

    // 5: response backpressure with requester 1 queued
    req0_valid = 1; req0_a = 32'hAAAA_AAAA; req0_b = 32'h5555_5555;
    req1_valid = 1; req1_a = 32'h8000_0000; req1_b = 32'h8000_0000;
    do_op(0, 32'hFFFF_FFFF, 0, 0, 0, 4'b0, 0, 8'h00, 10, 0, 0, 0);
    do_op(1, 32'h0000_0000, 1, 1, 0, 4'b0, 0, 8'h00, 0, 0, 0, 0);

    // 6: reset while the third slice is on the adder
    req0_valid = 1; req0_a = 32'h1234_5678; req0_b = 32'h0101_0101;
    @(negedge clk);
    chk("r6_ready", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("r6_idx2_add_a", add_a, 8'h34);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("r6_rsp_valid", rsp_valid, 0);
    chk("r6_add", {15'b0, add_a, add_b, add_cin}, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("r6_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'h0000_0100; req0_b = 32'h0000_0200;
    req1_valid = 1; req1_a = 32'h0000_0001; req1_b = 32'h0000_0001;
    do_op(0, 32'h0000_0300, 0, 0, 0, 4'b0, 0, 8'h00, 0, 0, 0, 0);
    req1_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_share_sequencer.md
Name: rca_share_sequencer

Overview:
Controller that time-shares one external SLICE-bit ripple-carry adder slice between two requesters. It performs WIDTH-bit add/subtract by sequencing the slice LSB-first over WIDTH/SLICE cycles and chaining the carry through a register. Round-robin arbitration and valid/ready handshakes sit on both request sides and on the response side. It sits between the arithmetic clients and the 8-bit ripple adder datapath.

Parameters:
WIDTH, 32, operand/result width; must be an integer multiple of SLICE, and WIDTH >= SLICE.
SLICE, 8, width of the external adder slice.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst_n  in  1  synchronous, active-low reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready.
req0_a  in  WIDTH  operand A, requester 0.
req0_b  in  WIDTH  operand B, requester 0.
req0_sub  in  1  1 = A-B, 0 = A+B, requester 0.
req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as above, for requester 1.
add_a  out  SLICE  slice operand A to the adder.
add_b  out  SLICE  slice operand B to the adder; already inverted for subtract.
add_cin  out  1  slice carry-in.
add_s  in  SLICE  slice sum from the adder; combinational from add_a/add_b/add_cin.
add_cout  in  1  slice carry-out from the adder.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer accepts the result.
rsp_sum  out  WIDTH  result.
rsp_cout  out  1  final carry; for subtract, 1 = no borrow.
rsp_ovf  out  1  signed overflow.
rsp_id  out  1  requester that owns the result.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all outputs 0 (rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, add_*, req*_ready).
  - last_grant=1, so requester 0 wins the first contested arbitration.
  - Reset mid-RUN or mid-DONE aborts the operation silently; no response is produced.
- FSM states: IDLE, RUN, DONE. NSLICE=WIDTH/SLICE; slice index idx is clog2(NSLICE) bits wide, minimum 1 bit.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, grant goes to the requester that is not last_grant.
  - reqN_ready is combinational: high only for the granted requester, only in IDLE. It may depend on the other requester's valid, never on the requester's own ready.
  - On valid&ready:
    - latch A.
    - latch B, XOR'd with {WIDTH{sub}}.
    - carry<=sub; idx<=0; id<=N; last_grant<=N; go to RUN.
- RUN, one slice per cycle:
  - add_a=A[idx*SLICE +: SLICE]; add_b=B'[same slice]; add_cin=carry.
  - At the edge: sum[slice]<=add_s; carry<=add_cout; idx<=idx+1.
  - Signed overflow is registered on the last slice: (A_msb==B'_msb) && (add_s msb != A_msb).
  - After the edge at idx=NSLICE-1, go to DONE.
  - add_* are driven 0 in every state other than RUN.
- DONE:
  - rsp_valid=1; rsp_sum/rsp_cout/rsp_ovf/rsp_id hold stable until rsp_valid&rsp_ready.
  - On that handshake go to IDLE. No new request is accepted in the DONE cycle; req*_ready stays 0.
- Latency: the handshake edge is cycle 0. RUN occupies cycles 1..NSLICE. rsp_valid is first high in cycle NSLICE+1 (cycle 5 for 32/8). Minimum issue interval is NSLICE+2 cycles.
- Request inputs are sampled only at acceptance; changing them afterwards has no effect.
- Output registers keep their last value after the response handshake. Only rsp_valid drops.
- Width rule: all arithmetic is modulo 2^WIDTH; rsp_cout is the carry out of the MSB slice.

Test Plan:
1. req0 A=0xFFFFFFFF, B=0x00000001, add, rsp_ready=1 -> rsp_valid in cycle 5; sum=0x00000000, cout=1, ovf=0, id=0. add_cin sequence is 0,1,1,1.
2. req1 A=0x7FFFFFFF, B=0x00000001, add -> sum=0x80000000, cout=0, ovf=1, id=1.
3. req0 subtract, A=5, B=7 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. First slice drives add_b=0xF8 and add_cin=1.
4. Both requesters valid continuously, with distinct operands and sub=0 -> grants alternate 0,1,0,1 (after reset, 0 first). The loser's ready stays 0 until it is granted; results arrive in the same order with correct ids.
5. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid and rsp_sum stay stable, both req*_ready stay 0, and a queued req1 is accepted only in the cycle after the response handshake.
6. rst_n=0 for one edge during RUN (idx=2) -> next cycle state is IDLE, rsp_valid=0, add_*=0. No response is emitted, and the next contested arbitration grants requester 0.
